icache_refill: RTL

Memory-side responder for the instruction-cache miss interface. It accepts a line-fill request (`missing_PC`/`missing_config`) and reads the 64-byte line from the byte-wide main RAM. It then assembles the 512-bit row and returns it with a one-cycle `return_config` strobe. It sits between the instruction fetch unit and the RAM port, and is read-only.

---
 rtl/icache_refill_if.sv | 31 +++
 rtl/icache_refill.sv | 96 +++++++++
 2 files changed

// File: rtl/icache_refill_if.sv
// Miss/refill bundle between fetch, the refill engine and the byte-wide RAM port.
// "slave" is the refill engine's view; "master" is the fetch/RAM environment.
interface icache_refill_if;
    logic [31:0]  missing_PC;
    logic         missing_config;
    logic [511:0] return_row;
    logic         return_config;
    logic [7:0]   mem_din;
    logic [31:0]  mem_a;
    logic         mem_wr;

    modport slave (
        input  missing_PC,
        input  missing_config,
        input  mem_din,
        output return_row,
        output return_config,
        output mem_a,
        output mem_wr
    );

    modport master (
        output missing_PC,
        output missing_config,
        output mem_din,
        input  return_row,
        input  return_config,
        input  mem_a,
        input  mem_wr
    );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: reads a 64-byte line byte by byte from main RAM,
// assembles the 512-bit row and returns it with a one-cycle strobe.
module icache_refill (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    icache_refill_if.slave bus
);
    localparam int LINE_BYTES = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q,  state_d;
    logic [31:0]  base_q,   base_d;
    logic [6:0]   icnt_q,   icnt_d;
    logic [5:0]   rcnt_q,   rcnt_d;
    logic         rv_q,     rv_d;
    logic [511:0] row_q,    row_d;
    logic         retCfg_q, retCfg_d;
    logic         issuing;

    assign issuing           = (state_q == READ) && (icnt_q < 7'(LINE_BYTES));
    assign bus.mem_a         = issuing ? base_q + {25'd0, icnt_q} : 32'd0;
    assign bus.mem_wr        = 1'b0;
    assign bus.return_row    = row_q;
    assign bus.return_config = retCfg_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        icnt_d   = icnt_q;
        rcnt_d   = rcnt_q;
        rv_d     = rv_q;
        row_d    = row_q;
        retCfg_d = retCfg_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (bus.missing_config) begin
                        base_d  = bus.missing_PC & 32'hFFFF_FFC0;
                        icnt_d  = 7'd0;
                        rv_d    = 1'b0;
                        state_d = READ;
                    end
                end
                READ: begin
                    if (rv_q) begin
                        row_d[{rcnt_q, 3'b000} +: 8] = bus.mem_din;
                    end
                    if (issuing) begin
                        rcnt_d = icnt_q[5:0];
                        rv_d   = 1'b1;
                        icnt_d = icnt_q + 7'd1;
                    end else begin
                        rv_d = 1'b0;
                    end
                    if (rv_q && rcnt_q == 6'd63) begin
                        retCfg_d = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    retCfg_d = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == READ && rv_q) begin
            // While stalled mem_din follows the held address, so the in-flight byte is re-read.
            icnt_d = {1'b0, rcnt_q};
            rv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= 32'd0;
            icnt_q   <= 7'd0;
            rcnt_q   <= 6'd0;
            rv_q     <= 1'b0;
            row_q    <= 512'd0;
            retCfg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            icnt_q   <= icnt_d;
            rcnt_q   <= rcnt_d;
            rv_q     <= rv_d;
            row_q    <= row_d;
            retCfg_q <= retCfg_d;
        end
    end
endmodule
